// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 key-matrix scanner.
package keypad_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned KEY_W    = 4;
  localparam int unsigned HIT_W    = NUM_COLS * NUM_ROWS;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } result_kind_t;

  typedef struct packed {
    result_kind_t      kind;
    logic [KEY_W-1:0]  code;
  } frame_result_t;

  // Bit index of the hit map equals the key code {col, row}.
  function automatic frame_result_t classify(input logic [HIT_W-1:0] hits);
    frame_result_t r;
    int unsigned   ones;
    ones   = 0;
    r.kind = NONE;
    r.code = '0;
    for (int unsigned i = 0; i < HIT_W; i++) begin
      if (hits[i]) begin
        ones   = ones + 1;
        r.code = KEY_W'(i);
      end
    end
    if (ones == 1)     r.kind = SINGLE;
    else if (ones > 1) r.kind = MULTI;
    return r;
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for asynchronous board inputs.
module row_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk0,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key-matrix scanner: column strobing, frame-based debounce,
// single press/release events per key.
import keypad_pkg::*;

module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 100_000,
  parameter int unsigned DEBOUNCE_SCANS = 5
) (
  input  logic                clk0,
  input  logic                reset_n,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_release,
  output logic                key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  logic [NUM_ROWS-1:0] row_s;
  logic [DIV_W-1:0]    div;
  logic [1:0]          col_idx;
  logic [HIT_W-1:0]    hit;
  logic [HIT_W-1:0]    frame_hits_c;
  frame_result_t       res_c;
  state_t              state;
  logic [KEY_W-1:0]    cand;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic                sample_c;
  logic                frame_end_c;
  logic                deb_done_c;
  logic                match_key_c;
  logic                match_cand_c;

  row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk0    (clk0),
    .reset_n (reset_n),
    .raw     (row),
    .synced  (row_s)
  );

  assign sample_c    = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_end_c = sample_c && (col_idx == 2'(NUM_COLS - 1));

  // Hit map including the column being sampled right now.
  always_comb begin
    frame_hits_c = hit;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (col_idx == 2'(c)) frame_hits_c[c*NUM_ROWS +: NUM_ROWS] = row_s;
    end
  end

  assign res_c        = classify(frame_hits_c);
  assign cnt_inc_c    = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign deb_done_c   = (cnt_inc_c >= CNT_W'(DEBOUNCE_SCANS));
  assign match_key_c  = (res_c.kind == SINGLE) && (res_c.code == key_code);
  assign match_cand_c = (res_c.kind == SINGLE) && (res_c.code == cand);

  // Column dwell divider, strobe rotation and hit-map capture.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      div     <= '0;
      col_idx <= '0;
      col     <= NUM_COLS'(1);
      hit     <= '0;
    end else if (sample_c) begin
      div     <= '0;
      col_idx <= col_idx + 2'd1;
      col     <= {col[NUM_COLS-2:0], col[NUM_COLS-1]};
      hit     <= frame_end_c ? '0 : frame_hits_c;
    end else begin
      div     <= div + DIV_W'(1);
    end
  end

  // Debounce FSM, advanced once per frame.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (frame_end_c) begin
        case (state)
          IDLE: begin
            if (res_c.kind == SINGLE) begin
              cand  <= res_c.code;
              cnt   <= CNT_W'(1);
              state <= PRESS_WAIT;
            end
          end
          PRESS_WAIT: begin
            case (res_c.kind)
              SINGLE: begin
                if (match_cand_c) begin
                  cnt <= cnt_inc_c;
                  if (deb_done_c) begin
                    key_code  <= cand;
                    key_valid <= 1'b1;
                    key_held  <= 1'b1;
                    state     <= HELD;
                  end
                end else begin
                  cand <= res_c.code;
                  cnt  <= CNT_W'(1);
                end
              end
              NONE:    state <= IDLE;
              default: ;  // MULTI freezes progress
            endcase
          end
          HELD: begin
            if (!match_key_c) begin
              cnt   <= CNT_W'(1);
              state <= RELEASE_WAIT;
            end
          end
          RELEASE_WAIT: begin
            if (match_key_c) begin
              state <= HELD;
            end else begin
              cnt <= cnt_inc_c;
              if (deb_done_c) begin
                key_release <= 1'b1;
                key_held    <= 1'b0;
                state       <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  logic        clk0 = 1'b0;
  logic        reset_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_release;
  logic        key_held;
  logic [15:0] keys;

  int vectors     = 0;
  int miscompares = 0;
  int nv          = 0;
  int nr          = 0;
  int both        = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk0        (clk0),
    .reset_n     (reset_n),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_release (key_release),
    .key_held    (key_held)
  );

  always #5 clk0 = ~clk0;

  // Pressed key (col c, row r) connects strobe c to return r.
  always_comb begin
    row = '0;
    for (int c = 0; c < 4; c++) begin
      if (col[c]) row = row | keys[c*4 +: 4];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
    if (key_valid === 1'b1)   nv++;
    if (key_release === 1'b1) nr++;
    if (key_valid === 1'b1 && key_release === 1'b1) both++;
  endtask

  task automatic frames(input int n);
    repeat (n * 16) step();
  endtask

  initial begin
    reset_n = 1'b0;
    keys    = '0;
    #12;
    chk("rst_col",     32'(col),         32'h1);
    chk("rst_code",    32'(key_code),    32'h0);
    chk("rst_valid",   32'(key_valid),   32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    chk("rst_held",    32'(key_held),    32'h0);
    #10 reset_n = 1'b1;

    // Column strobe rotation, then idle frames
    step(); step();
    chk("col_c0", 32'(col), 32'h1);
    step(); step();
    chk("col_c1", 32'(col), 32'h2);
    repeat (4) step();
    chk("col_c2", 32'(col), 32'h4);
    repeat (4) step();
    chk("col_c3", 32'(col), 32'h8);
    repeat (4) step();
    chk("col_wrap", 32'(col), 32'h1);
    frames(9);
    chk("idle_nv", 32'(nv), 32'd0);
    chk("idle_nr", 32'(nr), 32'd0);

    // Press and release key 6
    keys = 16'h0040; nv = 0;
    frames(2);
    chk("k6_early", 32'(nv), 32'd0);
    frames(1);
    chk("k6_valid", 32'(key_valid), 32'h1);
    chk("k6_code",  32'(key_code),  32'h6);
    chk("k6_held",  32'(key_held),  32'h1);
    chk("k6_nv",    32'(nv),        32'd1);
    keys = '0; nr = 0;
    frames(2);
    chk("k6_rel_early", 32'(nr),       32'd0);
    chk("k6_still_held", 32'(key_held), 32'h1);
    frames(1);
    chk("k6_release",  32'(key_release), 32'h1);
    chk("k6_unheld",   32'(key_held),    32'h0);
    chk("k6_nr",       32'(nr),          32'd1);
    chk("k6_code_kept", 32'(key_code),   32'h6);

    // Bounce on key B
    keys = 16'h0800; nv = 0;
    frames(2);
    keys = '0;
    frames(1);
    keys = 16'h0800;
    frames(2);
    chk("kb_early", 32'(nv), 32'd0);
    frames(1);
    chk("kb_valid", 32'(key_valid), 32'h1);
    chk("kb_code",  32'(key_code),  32'hB);
    chk("kb_nv",    32'(nv),        32'd1);
    keys = '0; nr = 0;
    frames(3);
    chk("kb_nr", 32'(nr), 32'd1);

    // Keys 1 and 6 together, then only key 1
    keys = 16'h0042; nv = 0;
    frames(5);
    chk("multi_nv",   32'(nv),       32'd0);
    chk("multi_held", 32'(key_held), 32'h0);
    keys = 16'h0002;
    frames(3);
    chk("k1_valid", 32'(key_valid), 32'h1);
    chk("k1_code",  32'(key_code),  32'h1);
    chk("k1_nv",    32'(nv),        32'd1);
    keys = '0; nr = 0;
    frames(3);
    chk("k1_nr", 32'(nr), 32'd1);

    // Switch from held 6 to 9
    keys = 16'h0040; nv = 0;
    frames(3);
    chk("sw6_valid", 32'(key_valid), 32'h1);
    chk("sw6_code",  32'(key_code),  32'h6);
    keys = 16'h0200; nv = 0; nr = 0;
    frames(3);
    chk("sw_release", 32'(key_release), 32'h1);
    chk("sw_nr",      32'(nr),          32'd1);
    chk("sw_nv",      32'(nv),          32'd0);
    chk("sw_unheld",  32'(key_held),    32'h0);
    frames(3);
    chk("sw9_valid", 32'(key_valid), 32'h1);
    chk("sw9_code",  32'(key_code),  32'h9);
    chk("sw9_nv",    32'(nv),        32'd1);
    keys = '0; nr = 0;
    frames(3);
    chk("sw9_nr", 32'(nr), 32'd1);

    // Reset during a key_valid pulse, key stays pressed
    keys = 16'h0040; nv = 0;
    frames(3);
    chk("pre_rst_valid", 32'(key_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("arst_valid",   32'(key_valid),   32'h0);
    chk("arst_held",    32'(key_held),    32'h0);
    chk("arst_code",    32'(key_code),    32'h0);
    chk("arst_release", 32'(key_release), 32'h0);
    chk("arst_col",     32'(col),         32'h1);
    @(negedge clk0);
    @(negedge clk0);
    reset_n = 1'b1;
    nv = 0;
    frames(2);
    chk("post_rst_early", 32'(nv), 32'd0);
    frames(1);
    chk("post_rst_valid", 32'(key_valid), 32'h1);
    chk("post_rst_code",  32'(key_code),  32'h6);
    chk("post_rst_held",  32'(key_held),  32'h1);

    chk("never_both", 32'(both), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the stopwatch's multiplexed 7-segment display driver: drives a 4×4 key matrix with one-hot column strobes and reads the row returns. It debounces the result across full scan frames and reports one clean press/release event per key. It sits between the board's key-matrix pins and the control logic (start/stop, preset entry), replacing per-switch shift-register debouncing.

## Interface
- SCAN_DIV, 100_000: clk0 cycles per column dwell (1 ms at 100 MHz); ≥4.
- DEBOUNCE_SCANS, 5: consecutive identical frame results needed to accept a press or release; 2..15.
- clk0  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- row  in  4  matrix row returns, active-high (external pull-downs), asynchronous to clk0.
- col  out  4  one-hot column strobe, active-high.
- key_code  out  4  code of accepted key = {col_idx[1:0], row_idx[1:0]}; held stable until the next accepted press.
- key_valid  out  1  one-cycle pulse on accepted press.
- key_release  out  1  one-cycle pulse on accepted release.
- key_held  out  1  high from key_valid until the cycle of key_release.

## Operation
- row passes a 2-flop synchronizer (sub-module row_sync); all logic uses the synchronized value.
- Divider div counts 0..SCAN_DIV-1, then wraps. col_idx (2 bits) advances on the wrap, 3→0 wraps. col = 4'b0001 << col_idx.
- Sample point: the cycle with div == SCAN_DIV-1. Synced rows for the current column are latched into hit[col_idx*4 +: 4].
- Frame end: the sample point with col_idx == 3. Frame result from the 16 hit bits:
  - zero bits set → NONE.
  - exactly one → SINGLE(code).
  - two or more → MULTI.
  - hit is cleared for the next frame.
- FSM, evaluated only at frame end. Counter cnt counts matching frames.
  - IDLE: on SINGLE(c), cand←c, cnt←1, go to PRESS_WAIT. Otherwise stay.
  - PRESS_WAIT:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS, key_code←cand, pulse key_valid, go to HELD.
    - SINGLE(other): cand←other, cnt←1.
    - NONE: go to IDLE.
    - MULTI: hold cnt; no advance, no reset.
  - HELD:
    - any result other than SINGLE(key_code) (NONE, MULTI, or a different key): cnt←1, go to RELEASE_WAIT.
    - SINGLE(key_code): stay.
  - RELEASE_WAIT:
    - result ≠ SINGLE(key_code): cnt+1. When cnt reaches DEBOUNCE_SCANS, pulse key_release, go to IDLE.
    - SINGLE(key_code): return to HELD with no pulse (bounce).
- A different key pressed while one is held gives release first. The new key is then accepted only via IDLE→PRESS_WAIT on later frames.
- cnt is 4 bits wide and saturates; it never wraps.

## Timing
- Reset values: col=4'b0001, key_code=0, key_valid=0, key_release=0, key_held=0, div=0, col_idx=0, hit=0, FSM=IDLE, synchronizer flops=0.
- reset_n assertion is immediate and asynchronous in any state, including mid-frame and during a pulse; the pulse is dropped.
- Deassertion starts a fresh frame at col_idx=0.
- One frame = 4·SCAN_DIV cycles. Row change to synced value: 2 cycles, always well inside the dwell because SCAN_DIV ≥ 4.
- key_valid and key_release are registered. Each is high for exactly the one cycle after the deciding frame-end sample point.
- Press latency, from the first frame containing the key: (DEBOUNCE_SCANS-1) frames + 1 cycle after that frame's end.
- key_held rises with key_valid and falls with key_release. key_valid and key_release are never high in the same cycle.

## Structure
- Shared package keypad_pkg: FSM state encoding (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), frame-result encoding (NONE, SINGLE, MULTI), and constant NUM_COLS=4 / NUM_ROWS=4.
- Sub-module row_sync: parameterized-width 2-flop synchronizer on clk0/reset_n, reusable for other board inputs.
- Everything else lives in keypad_scanner.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3, so one frame = 16 cycles.
- Reset, no input → col cycles 0001→0010→0100→1000 every 4 cycles; no pulses for 10 frames.
- row=4'b0100 whenever col=4'b0010 for 3 frames → key_valid 1 cycle, key_code=4'h6, key_held=1. Then row=0 for 3 frames → key_release 1 cycle, key_held=0.
- Bounce: key 4'hB present in frames 1 and 2, absent in frame 3, present in 4–6 → exactly one key_valid, after frame 6.
- Keys 4'h1 and 4'h6 both pressed for 5 frames → no key_valid (MULTI). Release 4'h6 → key_valid with key_code=4'h1 after 3 single frames.
- While 4'h6 is held, switch to 4'h9 → key_release after 3 frames, then key_valid with key_code=4'h9 after 3 more frames.
- Assert reset_n=0 in HELD during a key_valid cycle → all outputs 0 immediately. After release of reset with the key still held → fresh key_valid after 3 frames.
